// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard controller.
//   state_e   : FSM state encoding (RUN=0, LU_STALL=1, MEM_WAIT=2; 3 is illegal)
//   REG_ZERO  : index of the hard-wired zero register, never a real hazard source
// Optional feature macro used by importers: HAZARD_PERF_CNT_EN.
// -----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  localparam int unsigned REG_ZERO = 0;

endpackage : hazard_pkg

// File: rtl/hazard_wdog.sv
// -----------------------------------------------------------------------------
// hazard_wdog
// Data-memory wait watchdog. Counts consecutive cycles with the memory stall
// asserted (saturating at WAIT_MAX) and raises a sticky timeout flag when the
// count reaches WAIT_MAX. The flag clears only on reset.
// Ports:
//   clk_i     in  1  clock, posedge
//   rst_i     in  1  asynchronous active-high reset
//   stall_i   in  1  data memory not ready this cycle
//   timeout_o out 1  sticky timeout flag
// -----------------------------------------------------------------------------
module hazard_wdog #(
  parameter int WAIT_MAX = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic stall_i,
  output logic timeout_o
);

  localparam int                WCNT_W  = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WCNT_W-1:0] CNT_MAX = WCNT_W'(WAIT_MAX);

  logic [WCNT_W-1:0] cnt_d, cnt_q;
  logic              timeout_d, timeout_q;
  logic              reached;

  // cnt_d already includes the current stall cycle, so the flag is visible in
  // the very cycle that is the WAIT_MAX-th consecutive stall.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    cnt_d = '0;
    if (stall_i) begin
      cnt_d = (cnt_q != CNT_MAX) ? cnt_q + WCNT_W'(1) : cnt_q;
    end
    reached   = stall_i && (cnt_d == CNT_MAX);
    timeout_d = timeout_q || reached;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = !rst_i && timeout_d;

endmodule : hazard_wdog

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller: load-use stall, data-memory stall and
// branch/jump redirect flush. Outputs are Mealy (state + current inputs).
// Priority: dmem stall > load-use > redirect > normal.
// Ports:
//   clk_i, rst_i                 clock / asynchronous active-high reset
//   id_rs_i, id_rt_i, id_uses_rt_i  source registers of the IF/ID instruction
//   ex_memread_i, ex_rd_i        load sitting in ID/EX
//   branch_taken_i, jump_i       redirect resolved in ID
//   dmem_stall_i                 data memory not ready
//   pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o, ex_mem_hold_o
//   state_o                      current FSM state
//   mem_timeout_o                sticky dmem wait timeout
//   stall_cnt_o, flush_cnt_o     saturating perf counters (HAZARD_PERF_CNT_EN only)
// Optional feature macro: HAZARD_PERF_CNT_EN.
// -----------------------------------------------------------------------------
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rt_i,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              branch_taken_i,
  input  logic              jump_i,
  input  logic              dmem_stall_i,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic              if_id_flush_o,
  output logic              id_ex_bubble_o,
  output logic              ex_mem_hold_o,
  output logic [1:0]        state_o,
  output logic              mem_timeout_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

  state_e state_d, state_q;
  logic   lu_hit;
  logic   redirect;

  assign lu_hit = ex_memread_i
               && (ex_rd_i != REG_AW'(REG_ZERO))
               && ((ex_rd_i == id_rs_i) || (id_uses_rt_i && (ex_rd_i == id_rt_i)));
  assign redirect = branch_taken_i || jump_i;

  always_comb begin
    state_d        = ST_RUN;
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    ex_mem_hold_o  = 1'b0;

    case (state_q)
      // MEM_WAIT with the stall released evaluates exactly like RUN; LU_STALL
      // differs only in masking load-use so each hazard gets one bubble.
      ST_RUN, ST_LU_STALL, ST_MEM_WAIT: begin
        if (dmem_stall_i) begin
          // A coincident redirect is dropped; the held IF/ID re-presents it.
          pc_write_o    = 1'b0;
          if_id_write_o = 1'b0;
          ex_mem_hold_o = 1'b1;
          state_d       = ST_MEM_WAIT;
        end else if (lu_hit && (state_q != ST_LU_STALL)) begin
          pc_write_o     = 1'b0;
          if_id_write_o  = 1'b0;
          id_ex_bubble_o = 1'b1;
          state_d        = ST_LU_STALL;
        end else if (redirect) begin
          if_id_flush_o = 1'b1;
        end
      end
      // Illegal encoding: normal outputs for one cycle, then back to RUN.
      default: state_d = ST_RUN;
    endcase

    // Reset drains the pipeline front end: flush IF/ID, bubble ID/EX, freeze PC.
    if (rst_i) begin
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      if_id_flush_o  = 1'b1;
      id_ex_bubble_o = 1'b1;
      ex_mem_hold_o  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  assign state_o = state_q;

  hazard_wdog #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .stall_i   (dmem_stall_i),
    .timeout_o (mem_timeout_o)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write_o && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (if_id_flush_o && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed self-checking bench for hazard_ctrl. Inputs change 1 ns after the
// rising edge; outputs are compared 1 ns later, well before the next edge.
// Perf-counter checks are built only when HAZARD_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hazard_ctrl;

  localparam int REG_AW   = 5;
  localparam int WAIT_MAX = 255;
  localparam int CNT_W    = 16;

  // {pc_write, if_id_write, flush, bubble, hold}
  localparam logic [4:0] O_NORMAL = 5'b11000;
  localparam logic [4:0] O_LU     = 5'b00010;
  localparam logic [4:0] O_HOLD   = 5'b00001;
  localparam logic [4:0] O_FLUSH  = 5'b11100;
  localparam logic [4:0] O_RESET  = 5'b00110;

  logic              clk = 1'b0;
  logic              rst;
  logic [REG_AW-1:0] id_rs, id_rt, ex_rd;
  logic              id_uses_rt, ex_memread, branch_taken, jump, dmem_stall;
  logic              pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold;
  logic [1:0]        state;
  logic              mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;
`endif
  logic [4:0]        outs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign outs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold};

  hazard_ctrl #(
    .REG_AW   (REG_AW),
    .WAIT_MAX (WAIT_MAX),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .id_uses_rt_i   (id_uses_rt),
    .ex_memread_i   (ex_memread),
    .ex_rd_i        (ex_rd),
    .branch_taken_i (branch_taken),
    .jump_i         (jump),
    .dmem_stall_i   (dmem_stall),
    .pc_write_o     (pc_write),
    .if_id_write_o  (if_id_write),
    .if_id_flush_o  (if_id_flush),
    .id_ex_bubble_o (id_ex_bubble),
    .ex_mem_hold_o  (ex_mem_hold),
    .state_o        (state),
    .mem_timeout_o  (mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = '0; id_rt = '0; ex_rd = '0;
    id_uses_rt = 1'b0; ex_memread = 1'b0;
    branch_taken = 1'b0; jump = 1'b0; dmem_stall = 1'b0;
  endtask

  task automatic set_load_use(input logic [REG_AW-1:0] rd);
    ex_memread = 1'b1; ex_rd = rd; id_rs = rd;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_outs", 32'(outs), 32'(O_RESET));
    check("reset_timeout", 32'(mem_timeout), 32'd0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("post_reset_normal", 32'(outs), 32'(O_NORMAL));

    // Load-use on rs: one bubble, masked while in LU_STALL
    tick();
    set_load_use(5'd5);
    #1;
    check("lu_rs_outs", 32'(outs), 32'(O_LU));
    check("lu_rs_state", 32'(state), 32'd0);
    tick();
    check("lu_stall_state", 32'(state), 32'd1);
    check("lu_stall_masked", 32'(outs), 32'(O_NORMAL));
    tick();
    check("lu_back_run", 32'(state), 32'd0);
    idle_inputs();
    #1;
    check("lu_after_normal", 32'(outs), 32'(O_NORMAL));

    // Load-use through rt, and rt match ignored when rt is not read
    tick();
    ex_memread = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1; id_rs = 5'd1;
    #1;
    check("lu_rt_outs", 32'(outs), 32'(O_LU));
    id_uses_rt = 1'b0;
    #1;
    check("rt_unused_normal", 32'(outs), 32'(O_NORMAL));
    id_uses_rt = 1'b1;
    tick();
    idle_inputs();
    tick();
    check("lu_rt_run", 32'(state), 32'd0);

    // Load into r0 is never a hazard
    set_load_use(5'd0);
    #1;
    check("lu_r0_normal", 32'(outs), 32'(O_NORMAL));
    idle_inputs();

    // Jump flush, state stays RUN
    tick();
    jump = 1'b1;
    #1;
    check("jump_flush", 32'(outs), 32'(O_FLUSH));
    tick();
    check("jump_state_run", 32'(state), 32'd0);
    jump = 1'b0;

    // Branch coincident with dmem stall: hold only, flush after release
    tick();
    branch_taken = 1'b1; dmem_stall = 1'b1;
    #1;
    check("br_stall_hold", 32'(outs), 32'(O_HOLD));
    tick();
    check("br_stall_memwait", 32'(state), 32'd2);
    check("br_stall_hold2", 32'(outs), 32'(O_HOLD));
    dmem_stall = 1'b0;
    #1;
    check("br_release_flush", 32'(outs), 32'(O_FLUSH));
    tick();
    check("br_release_run", 32'(state), 32'd0);
    idle_inputs();

    // Load-use during dmem stall is taken when the stall releases
    tick();
    set_load_use(5'd3); dmem_stall = 1'b1;
    #1;
    check("lu_under_stall", 32'(outs), 32'(O_HOLD));
    tick();
    dmem_stall = 1'b0;
    #1;
    check("lu_from_memwait", 32'(outs), 32'(O_LU));
    tick();
    check("lu_from_memwait_state", 32'(state), 32'd1);
    idle_inputs();
    tick();

    // Watchdog: 300 consecutive stall cycles
    dmem_stall = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      #1;
      if (k == 1)   check("wd_c1_outs", 32'(outs), 32'(O_HOLD));
      if (k == 254) check("wd_c254_timeout", 32'(mem_timeout), 32'd0);
      if (k == 255) check("wd_c255_timeout", 32'(mem_timeout), 32'd1);
      if (k == 300) begin
        check("wd_c300_timeout", 32'(mem_timeout), 32'd1);
        check("wd_c300_state", 32'(state), 32'd2);
      end
      tick();
    end
    dmem_stall = 1'b0;
    #1;
    check("wd_release_outs", 32'(outs), 32'(O_NORMAL));
    check("wd_release_sticky", 32'(mem_timeout), 32'd1);
    tick();
    check("wd_release_run", 32'(state), 32'd0);
    check("wd_sticky_later", 32'(mem_timeout), 32'd1);

    // Reset in MEM_WAIT cycle 10
    dmem_stall = 1'b1;
    for (int k = 1; k < 10; k++) tick();
    check("memwait_c10_state", 32'(state), 32'd2);
    rst = 1'b1;
    #1;
    check("rst_memwait_state", 32'(state), 32'd0);
    check("rst_memwait_outs", 32'(outs), 32'(O_RESET));
    check("rst_clears_timeout", 32'(mem_timeout), 32'd0);
    tick();
    rst = 1'b0; dmem_stall = 1'b0;
    #1;
    check("rst_memwait_release", 32'(outs), 32'(O_NORMAL));
    tick();
    check("rst_memwait_run", 32'(state), 32'd0);

    // Reset in LU_STALL
    set_load_use(5'd9);
    tick();
    check("lu_pre_rst_state", 32'(state), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_lu_state", 32'(state), 32'd0);
    check("rst_lu_outs", 32'(outs), 32'(O_RESET));
`ifdef HAZARD_PERF_CNT_EN
    check("perf_reset_stall", 32'(stall_cnt), 32'd0);
    check("perf_reset_flush", 32'(flush_cnt), 32'd0);
`endif
    tick();
    idle_inputs();
    rst = 1'b0;
    #1;
    check("rst_lu_release", 32'(outs), 32'(O_NORMAL));

    // 3 load-use hazards and 2 jumps
    tick();
    for (int n = 0; n < 3; n++) begin
      set_load_use(REG_AW'(n + 1));
      #1;
      check("perf_lu_outs", 32'(outs), 32'(O_LU));
      tick();
      idle_inputs();
      tick();
    end
    for (int n = 0; n < 2; n++) begin
      jump = 1'b1;
      #1;
      check("perf_jump_outs", 32'(outs), 32'(O_FLUSH));
      tick();
      jump = 1'b0;
      tick();
    end
`ifdef HAZARD_PERF_CNT_EN
    check("perf_stall_cnt", 32'(stall_cnt), 32'd3);
    check("perf_flush_cnt", 32'(flush_cnt), 32'd2);
`endif
    check("final_state", 32'(state), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_hazard_ctrl
